// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;

   // DIV and REM interpret operands as two's complement.
   function automatic logic is_signed_op(input div_op_e op);
      return ~op[0];
   endfunction

   // REM and REMU return the remainder instead of the quotient.
   function automatic logic is_rem_op(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on magnitudes; purely combinational.
module div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic [DATA_WIDTH-1:0] quo,
   input  logic [DATA_WIDTH-1:0] dabs,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic [DATA_WIDTH-1:0] quo_next
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] trial;

   // The partial remainder is always below the divisor, so the shifted
   // value fits in W+1 bits and a non-negative trial fits back into W bits.
   assign shifted  = {rem, quo[DATA_WIDTH-1]};
   assign trial    = shifted - {1'b0, dabs};
   assign rem_next = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
   assign quo_next = {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with valid/ready on both
// sides; divide-by-zero and signed overflow bypass the iteration.
module div_seq
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic [1:0]            div_op,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   div_state_e            state_reg, state_next;
   logic [CW-1:0]         count_reg;
   logic [DATA_WIDTH-1:0] rem_reg, quo_reg, dabs_reg, result_reg;
   logic                  neg_q_reg, neg_r_reg, rem_sel_reg, out_valid_reg;

   div_op_e               op_in;
   logic                  sgn_in, dvd_neg, dvs_neg, div_zero, ovf, special, accept;
   logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs, special_res;
   logic [DATA_WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;

   assign op_in    = div_op_e'(div_op);
   assign sgn_in   = is_signed_op(op_in);
   assign dvd_neg  = sgn_in & dividend[DATA_WIDTH-1];
   assign dvs_neg  = sgn_in & divisor[DATA_WIDTH-1];
   assign dvd_abs  = dvd_neg ? -dividend : dividend;
   assign dvs_abs  = dvs_neg ? -divisor : divisor;
   assign div_zero = (divisor == '0);
   assign ovf      = sgn_in && (dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (divisor == '1);
   assign special  = div_zero | ovf;
   assign accept   = in_valid & in_ready & ~flush;

   // Results that are fixed by the operands alone and skip the iteration.
   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = is_rem_op(op_in) ? dividend : '1;
      end else if (ovf) begin
         special_res = is_rem_op(op_in) ? '0 : dividend;
      end
   end

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .dabs     (dabs_reg),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   assign q_fix = neg_q_reg ? -quo_reg : quo_reg;
   assign r_fix = neg_r_reg ? -rem_reg : rem_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode; flush overrides every transition.
   always_comb begin
      state_next = state_reg;
      in_ready   = (state_reg == IDLE);
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (count_reg == CW'(DATA_WIDTH-1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath: operand capture, iteration, sign fix-up and result hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg     <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         dabs_reg      <= '0;
         result_reg    <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         rem_sel_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= (state_next == DONE);
         if (flush) begin
            count_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: if (accept) begin
                  rem_sel_reg <= is_rem_op(op_in);
                  neg_q_reg   <= dvd_neg ^ dvs_neg;
                  neg_r_reg   <= dvd_neg;
                  quo_reg     <= dvd_abs;
                  rem_reg     <= '0;
                  dabs_reg    <= dvs_abs;
                  count_reg   <= '0;
                  if (special) result_reg <= special_res;
               end
               CALC: begin
                  rem_reg   <= rem_step;
                  quo_reg   <= quo_step;
                  count_reg <= count_reg + 1'b1;
               end
               FIX: result_reg <= rem_sel_reg ? r_fix : q_fix;
               default: ;
            endcase
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed scoreboard bench for div_seq.
module tb_div_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [1:0]   div_op = 2'b00;
   logic         in_ready, out_valid;
   logic [W-1:0] result;

   div_seq #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .div_op    (div_op),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int n_vec = 0;
   int n_err = 0;
   int accept_cycle = 0;
   bit rand_bp = 1'b0;

   logic [W-1:0] exp_res_q[$];
   int           exp_lat_q[$];
   string        exp_name_q[$];

   // RISC-V division semantics from plain arithmetic.
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
      longint sa, sb, q, r;
      if (b == 0) return op[1] ? a : {W{1'b1}};
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return op[1] ? W'(r) : W'(q);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op);
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Issue one operation; optionally register its expected response.
   task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input bit expect_out);
      int waited = 0;
      @(posedge clk); #1;
      while (!in_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL %s in_ready timeout: got 0, required 1", name);
         return;
      end
      dividend     = a;
      divisor      = b;
      div_op       = op;
      in_valid     = 1'b1;
      accept_cycle = cycle + 1;
      if (expect_out) begin
         exp_res_q.push_back(ref_result(a, b, op));
         exp_lat_q.push_back(ref_latency(a, b, op));
         exp_name_q.push_back(name);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      div_op   = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_res_q.size() != 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_res_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s drain timeout: got %0d pending, required 0", name, exp_res_q.size());
         exp_res_q.delete();
         exp_lat_q.delete();
         exp_name_q.delete();
      end
   endtask

   // Monitor: checks latency on the first valid cycle, result on handshake.
   initial begin
      bit seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !out_valid) begin
            seen = 1'b0;
         end else begin
            if (!seen) begin
               seen = 1'b1;
               if (exp_lat_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected out_valid: got 1, required 0 (result %h)", result);
               end else begin
                  check({exp_name_q[0], " latency"}, 32'(cycle - accept_cycle + 1),
                        32'(exp_lat_q[0]));
               end
            end
            if (out_ready) begin
               if (exp_res_q.size() != 0) begin
                  check({exp_name_q[0], " result"}, result, exp_res_q[0]);
                  $display("txn %s: result %h", exp_name_q[0], result);
                  void'(exp_res_q.pop_front());
                  void'(exp_lat_q.pop_front());
                  void'(exp_name_q.pop_front());
               end
               seen = 1'b0;
            end
         end
      end
   end

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic [1:0]   op;
      int           n;

      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", W'(in_ready), 1);
      check("reset out_valid", W'(out_valid), 0);
      check("reset result", result, 0);
      rst = 1'b0;

      do_op("DIVU 100/7", 100, 7, 2'b01, 1'b1);                         wait_drain("DIVU 100/7");
      do_op("REMU 100/7", 100, 7, 2'b11, 1'b1);                         wait_drain("REMU 100/7");
      do_op("DIV -7/2", -32'sd7, 2, 2'b00, 1'b1);                       wait_drain("DIV -7/2");
      do_op("REM -7/2", -32'sd7, 2, 2'b10, 1'b1);                       wait_drain("REM -7/2");
      do_op("REM 7/-2", 7, -32'sd2, 2'b10, 1'b1);                       wait_drain("REM 7/-2");
      do_op("DIVU 5/0", 5, 0, 2'b01, 1'b1);                             wait_drain("DIVU 5/0");
      do_op("REM 5/0", 5, 0, 2'b10, 1'b1);                              wait_drain("REM 5/0");
      do_op("DIV ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b1);      wait_drain("DIV ovf");
      do_op("REM ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b1);      wait_drain("REM ovf");
      do_op("DIVU 0/9", 0, 9, 2'b01, 1'b1);                             wait_drain("DIVU 0/9");
      do_op("DIVU max/1", 32'hFFFF_FFFF, 1, 2'b01, 1'b1);               wait_drain("DIVU max/1");

      // Backpressure: hold the result in DONE for 5 cycles.
      out_ready = 1'b0;
      do_op("bp DIVU 1000/10", 1000, 10, 2'b01, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", W'(out_valid), 1);
         check("bp result", result, 100);
         check("bp in_ready", W'(in_ready), 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp idle in_ready", W'(in_ready), 1);
      check("bp idle out_valid", W'(out_valid), 0);
      check("bp result hold", result, 100);
      wait_drain("bp");

      // Flush at CALC count 10.
      do_op("flush DIVU", 1234, 5, 2'b01, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush in_ready", W'(in_ready), 1);
      check("flush out_valid", W'(out_valid), 0);
      repeat (40) @(posedge clk);
      do_op("post-flush DIVU 9/3", 9, 3, 2'b01, 1'b1);                 wait_drain("post-flush");

      // Reset mid-CALC.
      do_op("rst DIV", -32'sd1000, 7, 2'b00, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst in_ready", W'(in_ready), 1);
      check("rst out_valid", W'(out_valid), 0);
      check("rst result", result, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      do_op("post-rst DIVU 9/3", 9, 3, 2'b01, 1'b1);                   wait_drain("post-rst");

      // Randomized operations with random consumer backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 80; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = 0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = W'($urandom_range(1, 15));
            3: a = W'($urandom_range(0, 15));
            4: b = -W'($urandom_range(1, 15));
            default: ;
         endcase
         do_op($sformatf("rand%0d op%0d %h/%h", i, op, a, b), a, b, op, 1'b1);
         wait_drain("rand");
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
